// File: rtl/synth_pkg.sv
// Shared types for the keyboard-to-voice path: note indices, voice states, keycode map.
// Pure definitions; no latency or flow control of its own.
// Imported by the allocator and its voice slots.
package synth_pkg;

    typedef logic [4:0] note_t;

    localparam note_t NOTE_NONE    = 5'd31;
    localparam note_t NOTE_DRUM_LO = 5'd15;

    typedef enum logic [1:0] {
        V_FREE,
        V_GATED,
        V_RELEASE
    } voice_state_t;

    // Piano row 0..13, guitar 14, drums 15..17; anything else is silence.
    function automatic note_t keycode_to_note(input logic [7:0] kc);
        case (kc)
            8'h04:   return 5'd0;
            8'h1A:   return 5'd1;
            8'h16:   return 5'd2;
            8'h08:   return 5'd3;
            8'h07:   return 5'd4;
            8'h09:   return 5'd5;
            8'h17:   return 5'd6;
            8'h0A:   return 5'd7;
            8'h1C:   return 5'd8;
            8'h0B:   return 5'd9;
            8'h18:   return 5'd10;
            8'h0D:   return 5'd11;
            8'h0E:   return 5'd12;
            8'h0F:   return 5'd13;
            8'h06:   return 5'd14;
            8'h05:   return 5'd15;
            8'h11:   return 5'd16;
            8'h2C:   return 5'd17;
            default: return NOTE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/voice_slot.sv
// One synth voice: FREE/GATED/RELEASE state, gate/release timer and saturating age.
// All outputs registered; an allocation is visible after the edge it is sampled on.
// No backpressure: allocation always wins over the slot's own timer transitions.
module voice_slot
    import synth_pkg::*;
#(
    parameter logic [23:0] RELEASE_CYCLES = 24'd4_800_000,
    parameter logic [23:0] ONESHOT_CYCLES = 24'd2_400_000,
    parameter int          AGE_W          = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             alloc_vld,
    input  note_t            alloc_note,
    input  logic             release_evt,
    output voice_state_t     state,
    output note_t            note,
    output logic [AGE_W-1:0] age,
    output logic             gate,
    output logic             busy,
    output logic             trig
);

    voice_state_t     state_q;
    voice_state_t     state_d;
    note_t            note_q;
    logic [23:0]      timer_q;
    logic [AGE_W-1:0] age_q;
    logic             trig_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            V_GATED: begin
                // Drums run a fixed gate length and never react to key release.
                if (note_q >= NOTE_DRUM_LO) begin
                    if (timer_q == ONESHOT_CYCLES - 24'd1) begin
                        state_d = V_RELEASE;
                    end
                end else if (release_evt) begin
                    state_d = V_RELEASE;
                end
            end
            V_RELEASE: begin
                if (timer_q == RELEASE_CYCLES - 24'd1) begin
                    state_d = V_FREE;
                end
            end
            default: ;
        endcase
        if (alloc_vld) begin
            state_d = V_GATED;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= V_FREE;
            note_q  <= NOTE_NONE;
            timer_q <= '0;
            age_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= alloc_vld;
            if (alloc_vld) begin
                note_q <= alloc_note;
            end
            // A steal of a GATED voice keeps the state but still restarts the gate.
            if (alloc_vld || state_d != state_q) begin
                timer_q <= '0;
            end else if (state_q != V_FREE) begin
                timer_q <= timer_q + 24'd1;
            end
            if (alloc_vld || state_d == V_FREE) begin
                age_q <= '0;
            end else if (age_q != '1) begin
                age_q <= age_q + 1'b1;
            end
        end
    end

    assign state = state_q;
    assign note  = note_q;
    assign age   = age_q;
    assign gate  = (state_q == V_GATED);
    assign busy  = (state_q != V_FREE);
    assign trig  = trig_q;

endmodule

// File: rtl/voice_allocator.sv
// Turns the keycode stream into note on/off events and assigns notes to a voice pool.
// One cycle: a keycode change before edge k shows on the voice outputs after edge k.
// No backpressure: when the pool is full the oldest voice is stolen; enable=0 defers events.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int          NUM_VOICES     = 4,
    parameter logic [23:0] RELEASE_CYCLES = 24'd4_800_000,
    parameter logic [23:0] ONESHOT_CYCLES = 24'd2_400_000,
    parameter int          AGE_W          = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      enable,
    input  logic [7:0]                keycode,
    output logic [NUM_VOICES*5-1:0]   voice_note,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [NUM_VOICES-1:0]     voice_trig,
    output logic [NUM_VOICES-1:0]     voice_busy
);

    note_t            prev_note;
    note_t            cur_note;
    logic             note_chg;
    logic             rel_vld;
    logic             press_vld;

    voice_state_t     st [NUM_VOICES];
    note_t            nt [NUM_VOICES];
    logic [AGE_W-1:0] ag [NUM_VOICES];

    logic [NUM_VOICES-1:0] rel_hit;
    logic [NUM_VOICES-1:0] pick;
    logic [NUM_VOICES-1:0] alloc;
    logic                  found;
    logic                  have;
    logic [AGE_W-1:0]      best_age;

    assign cur_note  = keycode_to_note(keycode);
    assign note_chg  = enable && (cur_note != prev_note);
    assign rel_vld   = note_chg && (prev_note != NOTE_NONE) && (prev_note < NOTE_DRUM_LO);
    assign press_vld = note_chg && (cur_note != NOTE_NONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_note <= NOTE_NONE;
        end else if (note_chg) begin
            prev_note <= cur_note;
        end
    end

    always_comb begin
        rel_hit = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            rel_hit[i] = rel_vld && (st[i] == V_GATED) && (nt[i] == prev_note);
        end
    end

    // Selection uses start-of-cycle states, so a voice released this cycle is still
    // GATED here and is only excluded from the GATED steal pass via rel_hit.
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        have     = 1'b0;
        best_age = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!found && st[i] == V_RELEASE && nt[i] == cur_note) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!found && st[i] == V_FREE) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!found && st[i] == V_RELEASE && (!have || ag[i] > best_age)) begin
                pick     = '0;
                pick[i]  = 1'b1;
                have     = 1'b1;
                best_age = ag[i];
            end
        end
        found    = found | have;
        have     = 1'b0;
        best_age = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!found && st[i] == V_GATED && !rel_hit[i] && (!have || ag[i] > best_age)) begin
                pick     = '0;
                pick[i]  = 1'b1;
                have     = 1'b1;
                best_age = ag[i];
            end
        end
    end

    assign alloc = press_vld ? pick : '0;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        voice_slot #(
            .RELEASE_CYCLES (RELEASE_CYCLES),
            .ONESHOT_CYCLES (ONESHOT_CYCLES),
            .AGE_W          (AGE_W)
        ) u_slot (
            .Clk         (Clk),
            .Reset       (Reset),
            .alloc_vld   (alloc[g]),
            .alloc_note  (cur_note),
            .release_evt (rel_hit[g]),
            .state       (st[g]),
            .note        (nt[g]),
            .age         (ag[g]),
            .gate        (voice_gate[g]),
            .busy        (voice_busy[g]),
            .trig        (voice_trig[g])
        );
        assign voice_note[5*g +: 5] = nt[g];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: 4 voices, 8-cycle release, 10-cycle drum gate.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// No backpressure involved; every step runs for a fixed number of cycles.
module tb_voice_allocator;

    logic        Clk;
    logic        Reset;
    logic        enable;
    logic [7:0]  keycode;
    logic [19:0] voice_note;
    logic [3:0]  voice_gate;
    logic [3:0]  voice_trig;
    logic [3:0]  voice_busy;

    int n_run;
    int n_fail;

    voice_allocator #(
        .NUM_VOICES     (4),
        .RELEASE_CYCLES (24'd8),
        .ONESHOT_CYCLES (24'd10),
        .AGE_W          (16)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .enable     (enable),
        .keycode    (keycode),
        .voice_note (voice_note),
        .voice_gate (voice_gate),
        .voice_trig (voice_trig),
        .voice_busy (voice_busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk20(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_run   = 0;
        n_fail  = 0;
        Reset   = 1'b1;
        enable  = 1'b1;
        keycode = 8'h00;
        tick(2);
        chk4("rst_busy", voice_busy, 4'b0000);
        chk4("rst_gate", voice_gate, 4'b0000);
        chk4("rst_trig", voice_trig, 4'b0000);
        chk20("rst_note", voice_note, 20'hFFFFF);

        // Single melodic press held for 10 cycles
        Reset   = 1'b0;
        keycode = 8'h04;
        tick(1);
        chk5("a_note0", voice_note[4:0], 5'd0);
        chk4("a_gate", voice_gate, 4'b0001);
        chk4("a_trig", voice_trig, 4'b0001);
        chk4("a_busy", voice_busy, 4'b0001);
        for (int k = 0; k < 9; k++) begin
            tick(1);
            chk4("a_trig_once", voice_trig, 4'b0000);
        end
        chk4("a_gate_held", voice_gate, 4'b0001);

        // Release tail of exactly 8 cycles
        keycode = 8'h00;
        tick(1);
        chk4("rel_gate", voice_gate, 4'b0000);
        chk4("rel_busy0", voice_busy, 4'b0001);
        for (int k = 0; k < 7; k++) begin
            tick(1);
            chk4("rel_busy", voice_busy, 4'b0001);
        end
        tick(1);
        chk4("rel_free", voice_busy, 4'b0000);
        chk5("rel_note_kept", voice_note[4:0], 5'd0);

        // a, w, s, e, d two cycles apart; d steals the oldest RELEASE voice
        keycode = 8'h04;
        tick(1);
        chk4("seq_a_trig", voice_trig, 4'b0001);
        tick(1);
        keycode = 8'h1A;
        tick(1);
        chk4("seq_w_trig", voice_trig, 4'b0010);
        chk4("seq_w_gate", voice_gate, 4'b0010);
        chk4("seq_w_busy", voice_busy, 4'b0011);
        tick(1);
        keycode = 8'h16;
        tick(1);
        chk4("seq_s_trig", voice_trig, 4'b0100);
        tick(1);
        keycode = 8'h08;
        tick(1);
        chk4("seq_e_trig", voice_trig, 4'b1000);
        chk4("seq_e_busy", voice_busy, 4'b1111);
        tick(1);
        keycode = 8'h07;
        tick(1);
        chk4("steal_trig", voice_trig, 4'b0001);
        chk4("steal_gate", voice_gate, 4'b0001);
        chk4("steal_busy", voice_busy, 4'b1111);
        chk20("steal_notes", voice_note, {5'd3, 5'd2, 5'd1, 5'd4});

        // Let the pool drain, then a held drum key
        keycode = 8'h00;
        tick(20);
        chk4("drain_busy", voice_busy, 4'b0000);
        keycode = 8'h2C;
        tick(1);
        chk5("drum_note", voice_note[4:0], 5'd17);
        chk4("drum_gate", voice_gate, 4'b0001);
        chk4("drum_trig", voice_trig, 4'b0001);
        for (int k = 0; k < 9; k++) begin
            tick(1);
            chk4("drum_gate_hold", voice_gate, 4'b0001);
        end
        tick(1);
        chk4("drum_gate_end", voice_gate, 4'b0000);
        chk4("drum_release", voice_busy, 4'b0001);
        tick(39);
        chk4("drum_free", voice_busy, 4'b0000);
        chk4("drum_no_retrig", voice_trig, 4'b0000);
        keycode = 8'h00;
        tick(1);
        chk4("drum_keyup", voice_busy, 4'b0000);

        // Re-press inside the release window retriggers the same voice
        keycode = 8'h04;
        tick(1);
        chk4("rt_first_trig", voice_trig, 4'b0001);
        tick(1);
        keycode = 8'h00;
        tick(1);
        chk4("rt_released", voice_gate, 4'b0000);
        tick(2);
        keycode = 8'h04;
        tick(1);
        chk4("rt_trig", voice_trig, 4'b0001);
        chk4("rt_gate", voice_gate, 4'b0001);
        chk4("rt_busy", voice_busy, 4'b0001);

        // enable low freezes event detection
        enable  = 1'b0;
        keycode = 8'h1A;
        tick(2);
        chk4("en_off_trig", voice_trig, 4'b0000);
        chk4("en_off_gate", voice_gate, 4'b0001);
        enable = 1'b1;
        tick(1);
        chk4("en_on_trig", voice_trig, 4'b0010);
        chk4("en_on_gate", voice_gate, 4'b0010);
        chk4("en_on_busy", voice_busy, 4'b0011);

        // Guitar note lands on the next free voice
        keycode = 8'h06;
        tick(1);
        chk5("gtr_note2", voice_note[14:10], 5'd14);
        chk4("gtr_gate", voice_gate, 4'b0100);
        chk4("gtr_busy", voice_busy, 4'b0111);

        // Reset with three busy voices, key 04 held through it
        Reset   = 1'b1;
        keycode = 8'h04;
        tick(1);
        chk4("mid_rst_busy", voice_busy, 4'b0000);
        chk4("mid_rst_gate", voice_gate, 4'b0000);
        chk20("mid_rst_note", voice_note, 20'hFFFFF);
        Reset = 1'b0;
        tick(1);
        chk4("post_rst_trig", voice_trig, 4'b0001);
        chk4("post_rst_gate", voice_gate, 4'b0001);
        chk20("post_rst_note", voice_note, {5'd31, 5'd31, 5'd31, 5'd0});
        tick(1);
        chk4("post_rst_trig_end", voice_trig, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
